segment_display_ctrl: RTL and testbench

Memory-mapped driver for an 8-digit, multiplexed, common-anode seven-segment display. Holds one 32-bit value, written through a byte-masked port and read back on read_data_o. Shows the value as 8 hex digits: digit k shows nibble k, digit 0 is the rightmost, least-significant nibble. Sits on the peripheral bus next to the CPU; its anode and cathode outputs drive the board display pins directly.

---
 rtl/segment_display_ctrl.sv | 106 ++++++++++
 tb/tb_segment_display_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/segment_display_ctrl.sv
// rtl/segment_display_ctrl.sv - 8-digit multiplexed common-anode seven-segment driver
// Optional build macro: SEGMENT_DISPLAY_ZERO_BLANK_EN (leading-zero blanking).
module segment_display_ctrl #(
  parameter int CLK_DIVISOR = 100000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  write_mask_i,
  output logic [31:0] read_data_o,
  output logic [7:0]  dsp_anode_o,
  output logic [7:0]  dsp_cathode_o
);

  localparam int CNT_W = (CLK_DIVISOR <= 1) ? 1 : $clog2(CLK_DIVISOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIVISOR - 1);

  logic [31:0]      value_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       digit_q;
  logic             tick;
  logic [3:0]       nibble;
  logic             blank;
  logic [7:0]       anode_d;
  logic [7:0]       cathode_d;

  // Active-high segment pattern (bits g..a) for a hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // Byte-masked value register; an all-zero mask is simply "no write".
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      value_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (write_mask_i[k]) begin
          value_q[8*k +: 8] <= write_data_i[8*k +: 8];
        end
      end
    end
  end

  assign read_data_o = value_q;
  assign tick        = (cnt_q == CNT_LAST);

  // Prescaler and digit index: the prescaler wrap advances the scan by one digit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      digit_q <= '0;
    end else if (tick) begin
      cnt_q   <= '0;
      digit_q <= digit_q + 3'd1;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Next anode/cathode pattern from the current value and digit index.
  always_comb begin
    nibble  = value_q[{digit_q, 2'b00} +: 4];
`ifdef SEGMENT_DISPLAY_ZERO_BLANK_EN
    // Blank when this digit and every more-significant one is zero; digit 0 always shows.
    blank   = (digit_q != 3'd0) && ((value_q >> {digit_q, 2'b00}) == 32'd0);
`else
    blank   = 1'b0;
`endif
    anode_d = ~(8'b1 << digit_q);
    if (blank) begin
      cathode_d = 8'hFF;
    end else begin
      cathode_d = {1'b1, ~glyph(nibble)};
    end
  end

  // Registered display pins; dark during reset, one cycle behind the scan state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dsp_anode_o   <= 8'hFF;
      dsp_cathode_o <= 8'hFF;
    end else begin
      dsp_anode_o   <= anode_d;
      dsp_cathode_o <= cathode_d;
    end
  end

endmodule

// File: tb/tb_segment_display_ctrl.sv
// tb/tb_segment_display_ctrl.sv - directed self-checking bench for segment_display_ctrl
module tb_segment_display_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] write_data_i;
  logic [3:0]  write_mask_i;
  logic [31:0] read_data_o;
  logic [7:0]  dsp_anode_o;
  logic [7:0]  dsp_cathode_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_cath [8];
  logic [7:0] zc;

  segment_display_ctrl #(.CLK_DIVISOR(4)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .write_data_i  (write_data_i),
    .write_mask_i  (write_mask_i),
    .read_data_o   (read_data_o),
    .dsp_anode_o   (dsp_anode_o),
    .dsp_cathode_o (dsp_cathode_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_digit(input string tag, input int k, input logic [7:0] cath);
    logic [7:0] an;
    an = ~(8'b1 << k);
    chk($sformatf("%s_anode_d%0d", tag, k), {24'd0, dsp_anode_o}, {24'd0, an});
    chk($sformatf("%s_cathode_d%0d", tag, k), {24'd0, dsp_cathode_o}, {24'd0, cath});
  endtask

  // Walks digits 1..7 (4 cycles each) from the last cycle of digit 0, then checks the wrap.
  task automatic scan_from_digit1(input string tag);
    for (int k = 1; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk_digit(tag, k, exp_cath[k]);
      end
    end
    step();
    chk_digit({tag, "_wrap"}, 0, exp_cath[0]);
  endtask

  initial begin
`ifdef SEGMENT_DISPLAY_ZERO_BLANK_EN
    zc = 8'hFF;
`else
    zc = 8'hC0;
`endif
    reset_i      = 1'b1;
    write_data_i = '0;
    write_mask_i = '0;
    step();
    step();
    chk("rst_anode",   {24'd0, dsp_anode_o},   32'hFF);
    chk("rst_cathode", {24'd0, dsp_cathode_o}, 32'hFF);
    chk("rst_read",    read_data_o,            32'h0);

    // First post-reset cycle: digit 0 showing "0".
    reset_i = 1'b0;
    step();
    chk_digit("post_rst", 0, 8'hC0);

    // Full-word write; new value visible on read one cycle later.
    write_data_i = 32'h12345678;
    write_mask_i = 4'hF;
    step();
    write_mask_i = 4'h0;
    chk("write_read", read_data_o, 32'h12345678);
    exp_cath = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    step();
    chk_digit("scan1", 0, 8'h80);
    step();
    chk_digit("scan1", 0, 8'h80);
    scan_from_digit1("scan1");

    // Byte-masked write and a zero mask.
    write_data_i = 32'hAABBCCDD;
    write_mask_i = 4'b0101;
    step();
    chk("mask_0101", read_data_o, 32'h12BB56DD);
    write_data_i = 32'hFFFFFFFF;
    write_mask_i = 4'b0000;
    step();
    chk("mask_0000", read_data_o, 32'h12BB56DD);

    // Hex letters, written on the first cycle after a reset.
    reset_i = 1'b1;
    step();
    reset_i      = 1'b0;
    write_data_i = 32'hFEDCBA98;
    write_mask_i = 4'hF;
    step();
    write_mask_i = 4'h0;
    chk_digit("hex_first", 0, 8'hC0);
    exp_cath = '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    for (int c = 0; c < 3; c++) begin
      step();
      chk_digit("hex", 0, 8'h80);
    end
    scan_from_digit1("hex");

    // Reset in the middle of digit 5's dwell.
    repeat (20) step();
    chk_digit("mid_d5", 5, 8'hA1);
    reset_i = 1'b1;
    step();
    chk("midrst_anode",   {24'd0, dsp_anode_o},   32'hFF);
    chk("midrst_cathode", {24'd0, dsp_cathode_o}, 32'hFF);
    chk("midrst_read",    read_data_o,            32'h0);
    reset_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_digit("resume", 0, 8'hC0);
    end
    step();
    chk_digit("resume", 1, zc);

    // Leading zeros: blanked only when the optional feature is built in.
    reset_i = 1'b1;
    step();
    reset_i      = 1'b0;
    write_data_i = 32'h00000042;
    write_mask_i = 4'hF;
    step();
    write_mask_i = 4'h0;
    exp_cath = '{8'hA4, 8'h99, zc, zc, zc, zc, zc, zc};
    for (int c = 0; c < 3; c++) begin
      step();
      chk_digit("v42", 0, 8'hA4);
    end
    scan_from_digit1("v42");

    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();
    exp_cath = '{8'hC0, zc, zc, zc, zc, zc, zc, zc};
    for (int c = 0; c < 3; c++) begin
      step();
      chk_digit("v0", 0, 8'hC0);
    end
    scan_from_digit1("v0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
